// File: rtl/cpc_ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Frame states, prefix bytes and keyboard protocol reply codes.
package cpc_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [7:0] RPL_ACK    = 8'hFA;
    localparam logic [7:0] RPL_BAT_OK = 8'hAA;
    localparam logic [7:0] RPL_ECHO   = 8'hEE;
    localparam logic [7:0] RPL_RESEND = 8'hFE;
    localparam logic [7:0] RPL_BAT_NG = 8'hFC;
    localparam logic [7:0] RPL_OVF0   = 8'h00;
    localparam logic [7:0] RPL_OVF1   = 8'hFF;

    function automatic logic is_reply(input logic [7:0] b);
        return (b == RPL_ACK)    || (b == RPL_BAT_OK) ||
               (b == RPL_ECHO)   || (b == RPL_RESEND) ||
               (b == RPL_BAT_NG) || (b == RPL_OVF0)   ||
               (b == RPL_OVF1);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser and glitch filter for one asynchronous PS/2 line.
// Produces the debounced level and a one-cycle pulse on its falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser, idle bus level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= line_i;
            s2_q <= s1_q;
        end
    end

    // Level moves only after FILTER_LEN consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state and registered fall pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan code set 2 receiver producing one-cycle key events.
// Handles E0/F0/E1 prefixes, drops protocol replies, aborts stalled frames.
module ps2_key_decoder
    import cpc_ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 12800
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam int WW = $clog2(TIMEOUT);

    logic         clk_lvl, clk_fall, fall;
    logic         d1_q, d2_q;

    frame_state_t state_q, state_d;
    logic [2:0]   bits_q, bits_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;

    logic [2:0]   skip_q, skip_d;
    logic         ext_q, ext_d;
    logic         brk_q, brk_d;
    logic         byte_ok;

    logic         stb_q, stb_d;
    logic         prs_q, prs_d;
    logic         exo_q, exo_d;
    logic [7:0]   code_q, code_d;
    logic         err_q, err_d;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filt (
        .clk    (clk),
        .reset_n(reset_n),
        .line_i (ps2_clk),
        .level_o(clk_lvl),
        .fall_o (clk_fall)
    );

    // A fall is honoured only while the filtered clock is actually low
    assign fall = clk_fall & ~clk_lvl;

    // Bare two-flop synchroniser for the data line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_q <= 1'b1;
            d2_q <= 1'b1;
        end else begin
            d1_q <= ps2_data;
            d2_q <= d1_q;
        end
    end

    // Frame FSM, watchdog, prefix tracking and event generation
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        par_d   = par_q;
        wd_d    = wd_q;
        skip_d  = skip_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        stb_d   = 1'b0;
        prs_d   = prs_q;
        exo_d   = exo_q;
        code_d  = code_q;
        err_d   = 1'b0;
        byte_ok = 1'b0;

        if (fall) begin
            wd_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!d2_q) begin
                        state_d = DATA;
                        bits_d  = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {d2_q, shift_q[7:1]};
                    bits_d  = bits_q + 3'd1;
                    if (bits_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = d2_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (d2_q && (^{shift_q, par_q})) begin
                        byte_ok = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        skip_d = 3'd0;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (wd_q == WW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                wd_d    = '0;
                err_d   = 1'b1;
                skip_d  = 3'd0;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end else begin
            wd_d = '0;
        end

        if (byte_ok) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == PFX_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (shift_q == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
                brk_d = 1'b1;
            end else if (is_reply(shift_q) && !ext_q && !brk_q) begin
                stb_d = 1'b0;
            end else begin
                stb_d  = 1'b1;
                code_d = shift_q;
                prs_d  = ~brk_q;
                exo_d  = ext_q;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bits_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            wd_q    <= '0;
            skip_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            stb_q   <= 1'b0;
            prs_q   <= 1'b0;
            exo_q   <= 1'b0;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            wd_q    <= wd_d;
            skip_q  <= skip_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            stb_q   <= stb_d;
            prs_q   <= prs_d;
            exo_q   <= exo_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    assign key_strobe   = stb_q;
    assign key_pressed  = prs_q;
    assign key_extended = exo_q;
    assign key_code     = code_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder.
// Table vectors, hand sequences and a random byte stream against a model.
module tb_ps2_key_decoder;

    localparam int TO = 2000;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe, key_pressed, key_extended, frame_err;
    logic [7:0] key_code;

    ps2_key_decoder #(
        .FILTER_LEN(8),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_strobe  (key_strobe),
        .key_pressed (key_pressed),
        .key_extended(key_extended),
        .key_code    (key_code),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Event monitor, sampled on the falling clock edge
    logic [9:0] ev_q[$];
    int err_n = 0;
    int dbl_n = 0;
    logic prev_stb = 1'b0;

    always @(negedge clk) begin
        if (key_strobe)
            ev_q.push_back({key_pressed, key_extended, key_code});
        if (frame_err) err_n++;
        if (key_strobe && prev_stb) dbl_n++;
        prev_stb = key_strobe;
    end

    task automatic clr_mon();
        ev_q.delete();
        err_n = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad,
                              input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (HP) @(negedge clk);
            if (glitch && i == 3) begin
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (HP) @(negedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    // Reference model: applies the byte-level rules to a stream
    int         m_skip;
    bit         m_ext, m_brk;
    int         m_err;
    logic [9:0] exp_q[$];

    function automatic bit reply_code(input logic [7:0] b);
        logic [7:0] r[7];
        r = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
        foreach (r[k]) if (r[k] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_err++;
            m_skip = 0;
            m_ext = 0;
            m_brk = 0;
        end else if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (reply_code(b) && !m_ext && !m_brk) begin
        end else begin
            exp_q.push_back({~m_brk, m_ext, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] b[9];
        logic [8:0] bad;
        int         ev;
        logic [7:0] code;
        logic       pr;
        logic       ex;
        int         err;
    } vec_t;

    vec_t tab[9];

    logic [7:0] pool[8];

    initial begin
        tab[0] = '{1, '{8'h1C, 0, 0, 0, 0, 0, 0, 0, 0},
                   9'h0, 1, 8'h1C, 1'b1, 1'b0, 0};
        tab[1] = '{2, '{8'hF0, 8'h1C, 0, 0, 0, 0, 0, 0, 0},
                   9'h0, 1, 8'h1C, 1'b0, 1'b0, 0};
        tab[2] = '{3, '{8'hE0, 8'hF0, 8'h75, 0, 0, 0, 0, 0, 0},
                   9'h0, 1, 8'h75, 1'b0, 1'b1, 0};
        tab[3] = '{1, '{8'h75, 0, 0, 0, 0, 0, 0, 0, 0},
                   9'h0, 1, 8'h75, 1'b1, 1'b0, 0};
        tab[4] = '{9, '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0,
                        8'h14, 8'hF0, 8'h77, 8'h29},
                   9'h0, 1, 8'h29, 1'b1, 1'b0, 0};
        tab[5] = '{1, '{8'h1C, 0, 0, 0, 0, 0, 0, 0, 0},
                   9'h1, 0, 8'h29, 1'b1, 1'b0, 1};
        tab[6] = '{1, '{8'h29, 0, 0, 0, 0, 0, 0, 0, 0},
                   9'h0, 1, 8'h29, 1'b1, 1'b0, 0};
        tab[7] = '{2, '{8'hFA, 8'hAA, 0, 0, 0, 0, 0, 0, 0},
                   9'h0, 0, 8'h29, 1'b1, 1'b0, 0};
        tab[8] = '{3, '{8'hE0, 8'hE0, 8'h6B, 0, 0, 0, 0, 0, 0},
                   9'h0, 1, 8'h6B, 1'b1, 1'b1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobe", 32'(key_strobe), 32'd0);
        check("rst_pressed", 32'(key_pressed), 32'd0);
        check("rst_ext", 32'(key_extended), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven vectors
        foreach (tab[r]) begin
            clr_mon();
            for (int i = 0; i < tab[r].n; i++)
                send_frame(tab[r].b[i], tab[r].bad[i], 11, 1'b0);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_events", r), ev_q.size(), tab[r].ev);
            check($sformatf("v%0d_code", r), 32'(key_code),
                  32'(tab[r].code));
            check($sformatf("v%0d_pressed", r), 32'(key_pressed),
                  32'(tab[r].pr));
            check($sformatf("v%0d_ext", r), 32'(key_extended),
                  32'(tab[r].ex));
            check($sformatf("v%0d_err", r), err_n, tab[r].err);
        end

        // Watchdog abort after 4 data bits, then recovery
        clr_mon();
        send_frame(8'h33, 1'b0, 5, 1'b0);
        repeat (TO + 200) @(negedge clk);
        check("wd_err", err_n, 1);
        check("wd_events", ev_q.size(), 0);
        send_frame(8'h5A, 1'b0, 11, 1'b0);
        repeat (20) @(negedge clk);
        check("wd_next_events", ev_q.size(), 1);
        check("wd_next_code", 32'(key_code), 32'h5A);
        check("wd_next_err", err_n, 1);

        // Short clock glitch inside a frame must add no bit
        clr_mon();
        send_frame(8'h1C, 1'b0, 11, 1'b1);
        repeat (20) @(negedge clk);
        check("glitch_events", ev_q.size(), 1);
        check("glitch_code", 32'(key_code), 32'h1C);
        check("glitch_err", err_n, 0);

        // Reset asserted mid-frame
        clr_mon();
        send_frame(8'h4B, 1'b0, 6, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mrst_code", 32'(key_code), 32'd0);
        check("mrst_flags",
              32'({key_strobe, key_pressed, key_extended, frame_err}),
              32'd0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        repeat (20) @(negedge clk);
        check("mrst_next_events", ev_q.size(), 1);
        check("mrst_next_code", 32'(key_code), 32'h29);
        check("mrst_next_err", err_n, 0);

        // Random byte stream against the model
        clr_mon();
        exp_q.delete();
        m_skip = 0;
        m_ext = 0;
        m_brk = 0;
        m_err = 0;
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'hFA,
                 8'hAA, 8'h00, 8'hFF, 8'h1C};
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit bad;
            if ($urandom_range(0, 2) == 0)
                b = pool[$urandom_range(0, 7)];
            else
                b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            model_byte(b, bad);
            send_frame(b, bad, 11, 1'b0);
        end
        repeat (20) @(negedge clk);
        check("rand_events", ev_q.size(), exp_q.size());
        check("rand_err", err_n, m_err);
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            check($sformatf("rand_ev%0d", i), 32'(ev_q[i]),
                  32'(exp_q[i]));

        check("strobe_width", dbl_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
